sseg_scan_driver: RTL and testbench
===================================

// Module: sseg_scan_driver
// PURPOSE
//   Time-multiplexed N-digit seven-segment display driver: the display end of the
//   hex-to-segment path. Takes a packed hex value plus per-digit DP/enable, scans
//   the common-anode digits one at a time, decodes each nibble internally.
//   Frame-synchronous update: a new value never shows mixed old/new digits.
// PARAMETERS
//   N_DIGITS      8       digits driven (1..8); width of AN, dp_in, digit_en
//   REFRESH_DIV   100000  clk cycles per digit slot (>=2); 100 MHz -> 1 kHz/digit
//   BLANK_CYCLES  1000    cycles at slot start with all anodes off (< REFRESH_DIV)
// PORTS
//   clk       in   1           system clock, all logic on rising edge
//   reset_n   in   1           synchronous reset, active-low
//   value     in   4*N_DIGITS  hex value; nibble k -> digit k (digit 0 = rightmost)
//   dp_in     in   N_DIGITS    decimal point request per digit, 1 = lit
//   digit_en  in   N_DIGITS    digit enable, 0 = digit dark for its whole slot
//   blank_lz  in   1           1 = suppress leading zero digits
//   load      in   1           1-cycle strobe: capture value/dp_in into staging
//   AN        out  N_DIGITS    anode selects, active-low
//   sseg      out  7           segments {g,f,e,d,c,b,a}, active-low
//   DP        out  1           decimal point, active-low
//   updated   out  1           1-cycle pulse: staging copied to display register
// BEHAVIOUR
//   Reset (reset_n=0 at edge): AN all 1, sseg 7'h7F, DP 1, updated 0, slot cnt 0,
//     digit idx 0, staging/display regs 0, pending 0. load ignored while in reset.
//   Slot counter cnt: 0..REFRESH_DIV-1, wraps; on wrap idx increments, N_DIGITS-1 -> 0.
//   Frame boundary: edge where idx==N_DIGITS-1 and cnt==REFRESH_DIV-1. At that edge,
//     if pending: display <= staging, pending <= 0, updated <= 1 (next cycle only).
//   load=1: staging <= {value, dp_in}, pending <= 1. load coincident with frame
//     boundary: the incoming value is copied straight to display (new data wins),
//     pending stays 0, updated pulses. Repeated loads in one frame: last one wins.
//   digit_en, blank_lz sampled live (not staged).
//   Digit visible iff digit_en[idx] and not lz-blanked. lz-blanked: blank_lz=1,
//     idx>0, and display nibbles idx..N_DIGITS-1 all zero. Digit 0 never lz-blanked.
//   Outputs registered, one cycle behind (idx,cnt):
//     cnt < BLANK_CYCLES or digit not visible -> AN all 1, sseg 7'h7F, DP 1.
//     else AN = ~(1<<idx), sseg = decode(display nibble idx), DP = ~dp[idx].
//   Decode (active-low {g..a}): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
//     8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
//   Disabled/blanked digits still consume their slot: frame = N_DIGITS*REFRESH_DIV
//     cycles always (constant brightness).
//   Never more than one AN bit low; AN goes all-high between any two digits.
//   Reset mid-frame: next edge returns everything to reset values; scan restarts at
//     digit 0, cnt 0; pending load discarded.
// TESTING  (N_DIGITS=8, REFRESH_DIV=4, BLANK_CYCLES=1)
//   1 reset_n=0 for 3 cycles -> AN=8'hFF, sseg=7'h7F, DP=1, updated=0 throughout.
//   2 load value=32'h000000A5, digit_en=8'hFF, blank_lz=0 -> updated pulse at next
//     frame boundary; then digit0: AN=8'hFE sseg=7'h12; digit1: AN=8'hFD sseg=7'h08;
//     digit2..7 sseg=7'h40; each AN low exactly 3 cycles, 1 all-high cycle between.
//   3 same value, blank_lz=1 -> digits 2..7 AN stay 8'hFF in their slots; 0,1 as in 2;
//     value=0 -> only digit0 shows 7'h40.
//   4 load new value during digit3 slot -> digits 4..7 of current frame show old
//     nibbles; updated pulses once at boundary; next frame fully new. load on the
//     boundary cycle itself -> new value in the very next frame.
//   5 dp_in=8'h02, digit_en=8'h0F -> DP=0 only while AN=8'hFD; AN never low for
//     digits 4..7; frame period still 32 cycles.
//   6 reset_n pulsed low during digit5 -> outputs at reset values next edge; after
//     release digit0 is first lit with sseg=7'h40 and no updated pulse.

Source files
------------

// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: time-multiplexed common-anode seven-segment driver.
// Scans one digit per slot, decodes hex nibbles internally and swaps the
// displayed value only at frame boundaries so a frame never mixes old/new data.
//
// Handshake: load is a one-cycle strobe with no back-pressure. Every cycle it
// is high, value/dp_in are captured into staging. updated pulses for one cycle
// on the cycle after staging (or a coincident load) lands in the display register.
module sseg_scan_driver #(
    parameter int N_DIGITS     = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic                  blank_lz,
    input  logic                  load,
    output logic [N_DIGITS-1:0]   AN,
    output logic [6:0]            sseg,
    output logic                  DP,
    output logic                  updated
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [4*N_DIGITS-1:0] stage_val;
    logic [N_DIGITS-1:0]   stage_dp;
    logic [4*N_DIGITS-1:0] disp_val;
    logic [N_DIGITS-1:0]   disp_dp;
    logic                  pending;

    logic                  slot_end;
    logic                  frame_end;
    logic [3:0]            nib_sel;
    logic                  dp_sel;
    logic                  en_sel;
    logic                  upper_nz;
    logic                  lz_blank;
    logic                  visible;
    logic [N_DIGITS-1:0]   an_on;

    // Active-low {g,f,e,d,c,b,a} hex glyphs.
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0: seg_decode = 7'h40;
            4'h1: seg_decode = 7'h79;
            4'h2: seg_decode = 7'h24;
            4'h3: seg_decode = 7'h30;
            4'h4: seg_decode = 7'h19;
            4'h5: seg_decode = 7'h12;
            4'h6: seg_decode = 7'h02;
            4'h7: seg_decode = 7'h78;
            4'h8: seg_decode = 7'h00;
            4'h9: seg_decode = 7'h10;
            4'hA: seg_decode = 7'h08;
            4'hB: seg_decode = 7'h03;
            4'hC: seg_decode = 7'h46;
            4'hD: seg_decode = 7'h21;
            4'hE: seg_decode = 7'h06;
            default: seg_decode = 7'h0E;
        endcase
    endfunction

    assign slot_end  = (cnt == CNT_MAX);
    assign frame_end = slot_end && (idx == IDX_MAX);

    // Select the current digit's nibble/dp/enable and detect leading-zero blanking.
    always_comb begin
        nib_sel  = 4'h0;
        dp_sel   = 1'b0;
        en_sel   = 1'b0;
        upper_nz = 1'b0;
        an_on    = '1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (IDX_W'(k) == idx) begin
                nib_sel  = disp_val[4*k +: 4];
                dp_sel   = disp_dp[k];
                en_sel   = digit_en[k];
                an_on[k] = 1'b0;
            end
            if ((IDX_W'(k) >= idx) && (disp_val[4*k +: 4] != 4'h0))
                upper_nz = 1'b1;
        end
        lz_blank = blank_lz && (idx != '0) && !upper_nz;
        visible  = en_sel && !lz_blank;
    end

    // Slot counter and digit index; every digit owns a full slot even when dark.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Staging capture and frame-synchronous transfer; a load on the boundary goes straight through.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stage_val <= '0;
            stage_dp  <= '0;
            disp_val  <= '0;
            disp_dp   <= '0;
            pending   <= 1'b0;
            updated   <= 1'b0;
        end else begin
            updated <= 1'b0;
            if (load) begin
                stage_val <= value;
                stage_dp  <= dp_in;
            end
            if (frame_end && load) begin
                disp_val <= value;
                disp_dp  <= dp_in;
                pending  <= 1'b0;
                updated  <= 1'b1;
            end else if (frame_end && pending) begin
                disp_val <= stage_val;
                disp_dp  <= stage_dp;
                pending  <= 1'b0;
                updated  <= 1'b1;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Registered display outputs, one cycle behind (idx, cnt); dark during blanking or when not visible.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            AN   <= '1;
            sseg <= 7'h7F;
            DP   <= 1'b1;
        end else if ((cnt < BLANK_LIM) || !visible) begin
            AN   <= '1;
            sseg <= 7'h7F;
            DP   <= 1'b1;
        end else begin
            AN   <= an_on;
            sseg <= seg_decode(nib_sel);
            DP   <= ~dp_sel;
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Testbench for sseg_scan_driver with N_DIGITS=8, REFRESH_DIV=4, BLANK_CYCLES=1.
// A frame is 32 cycles; edge i of a frame shows digit i/4, dark when i%4 == 0.
module tb_sseg_scan_driver;

    logic        clk;
    logic        reset_n;
    logic [31:0] value;
    logic [7:0]  dp_in;
    logic [7:0]  digit_en;
    logic        blank_lz;
    logic        load;
    logic [7:0]  AN;
    logic [6:0]  sseg;
    logic        DP;
    logic        updated;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;   // edges since reset release; edge index = cyc-1

    typedef struct {
        logic [31:0]     value;
        logic [7:0]      dp;
        logic [7:0]      en;
        logic            blz;
        logic [7:0]      lit;    // digits expected to light
        logic [7:0][6:0] seg;    // expected glyph per digit, [7] first in literals
    } vec_t;

    vec_t vtbl [7];
    vec_t zero_v;
    vec_t new_b;

    sseg_scan_driver #(
        .N_DIGITS    (8),
        .REFRESH_DIV (4),
        .BLANK_CYCLES(1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .value   (value),
        .dp_in   (dp_in),
        .digit_en(digit_en),
        .blank_lz(blank_lz),
        .load    (load),
        .AN      (AN),
        .sseg    (sseg),
        .DP      (DP),
        .updated (updated)
    );

    // Clock and edge counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset_n) cyc = 0;
        else          cyc = cyc + 1;
    end

    task automatic check_reset(input string name);
        n_tests++;
        if ({AN, sseg, DP, updated} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL %s: AN=%h sseg=%h DP=%b upd=%b, want AN=ff sseg=7f DP=1 upd=0",
                     name, AN, sseg, DP, updated);
        end
    endtask

    task automatic check_cycle(input vec_t v, input int i, input logic exp_upd);
        int d;
        int c;
        logic [7:0] ean;
        logic [6:0] es;
        logic       edp;
        d = i / 4;
        c = i % 4;
        if (c == 0 || !v.lit[d]) begin
            ean = 8'hFF; es = 7'h7F; edp = 1'b1;
        end else begin
            ean = 8'hFF; ean[d] = 1'b0; es = v.seg[d]; edp = ~v.dp[d];
        end
        n_tests++;
        if ({AN, sseg, DP, updated} !== {ean, es, edp, exp_upd}) begin
            n_fail++;
            $display("FAIL scan val=%h i=%0d: AN=%h sseg=%h DP=%b upd=%b, want AN=%h sseg=%h DP=%b upd=%b",
                     v.value, i, AN, sseg, DP, updated, ean, es, edp, exp_upd);
        end
    endtask

    // Align to the first edge of the next frame and check all 32 cycles; ends at i=31.
    task automatic check_frame(input vec_t v, input logic upd_end);
        for (int g = 0; g < 64 && (cyc % 32) != 1; g++) @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            check_cycle(v, i, (i == 31) && upd_end);
            if (i < 31) @(negedge clk);
        end
    endtask

    task automatic wait_updated(input string name);
        logic seen;
        seen = 1'b0;
        for (int g = 0; g < 40; g++) begin
            if (updated === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: updated=0 after 40 cycles, want a pulse", name);
        end
    endtask

    // Drive a vector with a one-cycle load, then check the first frame that shows it.
    task automatic apply_vec(input vec_t v);
        value = v.value; dp_in = v.dp; digit_en = v.en; blank_lz = v.blz; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_updated("updated_after_load");
        check_frame(v, 1'b0);
    endtask

    initial begin
        vtbl[0] = '{value:32'h000000A5, dp:8'h00, en:8'hFF, blz:1'b0, lit:8'hFF,
                    seg:{7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h08,7'h12}};
        vtbl[1] = '{value:32'h000000A5, dp:8'h00, en:8'hFF, blz:1'b1, lit:8'h03,
                    seg:{7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h08,7'h12}};
        vtbl[2] = '{value:32'h00000000, dp:8'h00, en:8'hFF, blz:1'b1, lit:8'h01,
                    seg:{7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40}};
        vtbl[3] = '{value:32'h000000A5, dp:8'h02, en:8'h0F, blz:1'b0, lit:8'h0F,
                    seg:{7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h08,7'h12}};
        vtbl[4] = '{value:32'hFEDCBA98, dp:8'hFF, en:8'hFF, blz:1'b0, lit:8'hFF,
                    seg:{7'h0E,7'h06,7'h21,7'h46,7'h03,7'h08,7'h10,7'h00}};
        vtbl[5] = '{value:32'h76543210, dp:8'h80, en:8'hAA, blz:1'b1, lit:8'hAA,
                    seg:{7'h78,7'h02,7'h12,7'h19,7'h30,7'h24,7'h79,7'h40}};
        vtbl[6] = '{value:32'h00300100, dp:8'h00, en:8'hFF, blz:1'b1, lit:8'h3F,
                    seg:{7'h40,7'h40,7'h30,7'h40,7'h40,7'h79,7'h40,7'h40}};
        zero_v  = '{value:32'h0, dp:8'h00, en:8'hFF, blz:1'b0, lit:8'hFF,
                    seg:{7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40}};
        new_b   = '{value:32'h76543210, dp:8'h00, en:8'hFF, blz:1'b0, lit:8'hFF,
                    seg:{7'h78,7'h02,7'h12,7'h19,7'h30,7'h24,7'h79,7'h40}};

        // Reset held 3 cycles with load asserted: load must be ignored.
        reset_n = 1'b0; load = 1'b1; value = 32'hFFFFFFFF; dp_in = 8'hFF;
        digit_en = 8'hFF; blank_lz = 1'b0;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            check_reset("reset_hold");
        end
        reset_n = 1'b1; load = 1'b0; value = 32'h0; dp_in = 8'h00;
        check_frame(zero_v, 1'b0);

        // Table-driven vectors
        for (int t = 0; t < 7; t++) apply_vec(vtbl[t]);

        // Load mid-frame (digit3 slot): rest of the frame stays old, next frame new.
        apply_vec(vtbl[4]);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check_cycle(vtbl[4], i, i == 31);
            if (i == 13) begin
                value = new_b.value; dp_in = new_b.dp; load = 1'b1;
            end
            if (i == 14) load = 1'b0;
        end
        check_frame(new_b, 1'b0);

        // Load on the boundary edge itself: shown in the very next frame, no second pulse.
        repeat (31) @(negedge clk);
        value = vtbl[4].value; dp_in = vtbl[4].dp; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n_tests++;
        if (updated !== 1'b1) begin
            n_fail++;
            $display("FAIL boundary_load_updated: updated=%b, want 1", updated);
        end
        check_frame(vtbl[4], 1'b0);

        // Reset during digit5 with a pending load: pending discarded, scan restarts.
        repeat (22) @(negedge clk);
        value = 32'h11111111; load = 1'b1;
        @(negedge clk);
        load = 1'b0; reset_n = 1'b0;
        @(negedge clk);
        check_reset("reset_mid_frame");
        reset_n = 1'b1;
        check_frame(zero_v, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
